vram_arbiter: RTL and testbench

- Shares the single-port 8192x8 VRAM between the CPU bus port and the PPU renderer's pixel fetcher.
- Ownership follows the PPU phase: the renderer owns VRAM exclusively during PHASE_DRAW, and the CPU owns it otherwise.
- CPU accesses that land in DRAW are either answered (reads return 0xFF) or parked in a one-entry posted-write buffer that retires when DRAW ends.
- Sits between ppu_m's bus-side VRAM port and the sp_8192w_8b instance, and replaces the combinational phase mux.

---
 rtl/ppu_pkg.sv | 32 +++
 rtl/post_wr_buf.sv | 41 ++++
 rtl/vram_arbiter.sv | 106 ++++++++++
 tb/tb_vram_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// Shared PPU types: renderer phases, LCDC register layout, VRAM geometry and
// the posted-write buffer state encoding used by the VRAM arbiter.
package ppu_pkg;

  localparam int unsigned VRAM_AW = 13;
  localparam int unsigned VRAM_DW = 8;

  typedef enum logic [1:0] {
    PHASE_HBLANK = 2'd0,
    PHASE_VBLANK = 2'd1,
    PHASE_OAM    = 2'd2,
    PHASE_DRAW   = 2'd3
  } ppu_phase_t;

  typedef struct packed {
    logic ena;
    logic win_map;
    logic win_ena;
    logic bg_tiles;
    logic bg_map;
    logic obj_size;
    logic obj_ena;
    logic bg_ena;
  } lcdc_t;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_FULL  = 2'd1,
    DRAIN     = 2'd2
  } vbuf_state_t;

endpackage

// File: rtl/post_wr_buf.sv
// One-entry posted-write buffer: holds a CPU write captured during DRAW and
// sequences its single-cycle drain once the renderer releases VRAM.
module post_wr_buf
  import ppu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               draw_own,
  input  logic               push,
  input  logic [VRAM_AW-1:0] push_addr,
  input  logic [VRAM_DW-1:0] push_data,
  output vbuf_state_t        state,
  output logic [VRAM_AW-1:0] buf_addr,
  output logic [VRAM_DW-1:0] buf_data
);

  // Buffer state machine with the captured address/data alongside it
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= BUF_EMPTY;
      buf_addr <= '0;
      buf_data <= '0;
    end else begin
      case (state)
        BUF_EMPTY: begin
          if (push) begin
            state    <= BUF_FULL;
            buf_addr <= push_addr;
            buf_data <= push_data;
          end
        end
        BUF_FULL: begin
          if (!draw_own) state <= DRAIN;
        end
        DRAIN:   state <= BUF_EMPTY;
        default: state <= BUF_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Arbitrates the single-port VRAM between the CPU bus port and the PPU pixel
// fetcher. The renderer owns VRAM during DRAW; CPU writes landing in DRAW are
// posted (or dropped), CPU reads in DRAW return open bus.
module vram_arbiter
  import ppu_pkg::*;
#(
  parameter bit               POST_WRITES = 1'b1,
  parameter logic [VRAM_DW-1:0] OPEN_BUS  = 8'hFF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               lcd_ena,
  input  logic [1:0]         phase,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [VRAM_AW-1:0] cpu_addr,
  input  logic [VRAM_DW-1:0] cpu_wdata,
  output logic               cpu_ready,
  output logic               cpu_rvalid,
  output logic [VRAM_DW-1:0] cpu_rdata,
  input  logic               ren_req,
  input  logic [VRAM_AW-1:0] ren_addr,
  output logic               ren_gnt,
  output logic [VRAM_DW-1:0] ren_rdata,
  output logic [VRAM_AW-1:0] mem_addr,
  output logic               mem_we,
  output logic [VRAM_DW-1:0] mem_din,
  input  logic [VRAM_DW-1:0] mem_dout,
  output logic [7:0]         wr_dropped
);

  vbuf_state_t        buf_state;
  logic [VRAM_AW-1:0] buf_addr;
  logic [VRAM_DW-1:0] buf_data;
  logic               draw_own;
  logic               draining;
  logic               cpu_accept;
  logic               push;
  logic               drop;
  logic               rd_open_q;

  assign draw_own   = lcd_ena && (phase == PHASE_DRAW);
  assign draining   = (buf_state == DRAIN);
  assign cpu_accept = cpu_req && cpu_ready;
  assign push       = POST_WRITES && cpu_accept && cpu_we && draw_own;
  assign drop       = !POST_WRITES && cpu_accept && cpu_we && draw_own;

  post_wr_buf u_post_wr_buf (
    .clk      (clk),
    .rst      (rst),
    .draw_own (draw_own),
    .push     (push),
    .push_addr(cpu_addr),
    .push_data(cpu_wdata),
    .state    (buf_state),
    .buf_addr (buf_addr),
    .buf_data (buf_data)
  );

  // VRAM port mux, CPU handshake and renderer grant
  always_comb begin
    cpu_ready = 1'b1;
    ren_gnt   = 1'b0;
    mem_addr  = cpu_addr;
    mem_we    = 1'b0;
    mem_din   = cpu_wdata;
    if (draining) begin
      cpu_ready = 1'b0;
      mem_addr  = buf_addr;
      mem_din   = buf_data;
      mem_we    = 1'b1;
    end else if (draw_own) begin
      mem_addr = ren_addr;
      ren_gnt  = ren_req;
      if (POST_WRITES && cpu_we && (buf_state == BUF_FULL)) cpu_ready = 1'b0;
    end else if (buf_state == BUF_FULL) begin
      // CPU is held until the buffered write has drained so a newer access
      // can never be overtaken by the older posted write
      cpu_ready = 1'b0;
      mem_addr  = ren_addr;
      ren_gnt   = ren_req;
    end else begin
      mem_we  = cpu_req && cpu_we;
      ren_gnt = ren_req && !cpu_req;
      // An idle CPU lets a granted fetch actually address its own location
      if (ren_req && !cpu_req) mem_addr = ren_addr;
    end
  end

  // Read-return pulse, open-bus flag and dropped-write counter
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_rvalid <= 1'b0;
      rd_open_q  <= 1'b1;
      wr_dropped <= '0;
    end else begin
      cpu_rvalid <= cpu_accept && !cpu_we;
      if (cpu_accept && !cpu_we) rd_open_q <= draw_own;
      if (drop && (wr_dropped != 8'hFF)) wr_dropped <= wr_dropped + 8'd1;
    end
  end

  assign cpu_rdata = rd_open_q ? OPEN_BUS : mem_dout;
  assign ren_rdata = mem_dout;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: one posting instance and one dropping
// instance, each backed by a negedge-clocked 8192x8 VRAM model.
module tb_vram_arbiter;

  localparam logic [1:0] HB = 2'd0;
  localparam logic [1:0] VB = 2'd1;
  localparam logic [1:0] OA = 2'd2;
  localparam logic [1:0] DR = 2'd3;

  logic        clk = 1'b0;
  logic        rst, load, lcd_ena, cpu_req, cpu_we, ren_req, d_cpu_req, d_cpu_we;
  logic [1:0]  phase;
  logic [12:0] cpu_addr, ren_addr;
  logic [7:0]  cpu_wdata;

  logic        cpu_ready, cpu_rvalid, ren_gnt, mem_we;
  logic [7:0]  cpu_rdata, ren_rdata, mem_din, wr_dropped;
  logic [12:0] mem_addr;
  logic [7:0]  dout0;
  logic        cpu_ready_d, cpu_rvalid_d, ren_gnt_d, mem_we_d;
  logic [7:0]  cpu_rdata_d, ren_rdata_d, mem_din_d, wr_dropped_d;
  logic [12:0] mem_addr_d;
  logic [7:0]  dout1;

  logic [7:0] mem0 [8192];
  logic [7:0] mem1 [8192];

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input int i);
    if (i == 32'h1800) return 8'h42;
    return 8'(i * 7 + 3);
  endfunction

  vram_arbiter #(.POST_WRITES(1'b1), .OPEN_BUS(8'hFF)) u_dut (
    .clk(clk), .rst(rst), .lcd_ena(lcd_ena), .phase(phase),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ren_req(ren_req), .ren_addr(ren_addr), .ren_gnt(ren_gnt), .ren_rdata(ren_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(dout0),
    .wr_dropped(wr_dropped)
  );

  vram_arbiter #(.POST_WRITES(1'b0), .OPEN_BUS(8'hFF)) u_drop (
    .clk(clk), .rst(rst), .lcd_ena(lcd_ena), .phase(phase),
    .cpu_req(d_cpu_req), .cpu_we(d_cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready_d), .cpu_rvalid(cpu_rvalid_d), .cpu_rdata(cpu_rdata_d),
    .ren_req(ren_req), .ren_addr(ren_addr), .ren_gnt(ren_gnt_d), .ren_rdata(ren_rdata_d),
    .mem_addr(mem_addr_d), .mem_we(mem_we_d), .mem_din(mem_din_d), .mem_dout(dout1),
    .wr_dropped(wr_dropped_d)
  );

  // VRAM models: clocked on ~clk, read-first, data visible the next cycle
  always @(negedge clk) begin
    if (load) begin
      for (int i = 0; i < 8192; i++) begin
        mem0[i] <= pat(i);
        mem1[i] <= pat(i);
      end
    end else begin
      if (mem_we) mem0[mem_addr] <= mem_din;
      if (mem_we_d) mem1[mem_addr_d] <= mem_din_d;
    end
    dout0 <= mem0[mem_addr];
    dout1 <= mem1[mem_addr_d];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic l, input logic [1:0] ph, input logic rq, input logic we,
                       input logic [12:0] a, input logic [7:0] wd, input logic rr,
                       input logic [12:0] ra);
    lcd_ena = l; phase = ph; cpu_req = rq; cpu_we = we;
    cpu_addr = a; cpu_wdata = wd; ren_req = rr; ren_addr = ra;
  endtask

  typedef struct {
    logic        lcd;
    logic [1:0]  ph;
    logic        rq;
    logic        we;
    logic [12:0] addr;
    logic [7:0]  wd;
    logic        rr;
    logic [12:0] raddr;
    logic        e_ready;
    logic        e_gnt;
    logic        e_we;
    logic [12:0] e_maddr;
    logic        e_rvalid;
    logic [7:0]  e_rdata;
  } vec_t;

  vec_t vecs [9];

  initial begin
    vecs[0] = '{1'b1, HB, 1'b1, 1'b0, 13'h0020, 8'h00, 1'b1, 13'h1800, 1'b1, 1'b0, 1'b0, 13'h0020, 1'b1, 8'hE3};
    vecs[1] = '{1'b1, HB, 1'b0, 1'b0, 13'h0033, 8'h00, 1'b1, 13'h1801, 1'b1, 1'b1, 1'b0, 13'h1801, 1'b0, 8'h00};
    vecs[2] = '{1'b1, HB, 1'b1, 1'b1, 13'h0100, 8'h5A, 1'b1, 13'h1800, 1'b1, 1'b0, 1'b1, 13'h0100, 1'b0, 8'h00};
    vecs[3] = '{1'b1, DR, 1'b1, 1'b0, 13'h0005, 8'h00, 1'b1, 13'h1800, 1'b1, 1'b1, 1'b0, 13'h1800, 1'b1, 8'hFF};
    vecs[4] = '{1'b0, DR, 1'b1, 1'b0, 13'h0020, 8'h00, 1'b1, 13'h1800, 1'b1, 1'b0, 1'b0, 13'h0020, 1'b1, 8'hE3};
    vecs[5] = '{1'b1, VB, 1'b0, 1'b0, 13'h0044, 8'h00, 1'b0, 13'h1802, 1'b1, 1'b0, 1'b0, 13'h0044, 1'b0, 8'h00};
    vecs[6] = '{1'b1, OA, 1'b1, 1'b1, 13'h0200, 8'h66, 1'b0, 13'h1802, 1'b1, 1'b0, 1'b1, 13'h0200, 1'b0, 8'h00};
    vecs[7] = '{1'b1, DR, 1'b0, 1'b0, 13'h0044, 8'h00, 1'b0, 13'h1803, 1'b1, 1'b0, 1'b0, 13'h1803, 1'b0, 8'h00};
    vecs[8] = '{1'b1, HB, 1'b1, 1'b0, 13'h0100, 8'h00, 1'b0, 13'h0000, 1'b1, 1'b0, 1'b0, 13'h0100, 1'b1, 8'h5A};

    // Reset and VRAM preload
    rst = 1'b1; load = 1'b1; d_cpu_req = 1'b0; d_cpu_we = 1'b0;
    drive(1'b1, HB, 1'b0, 1'b0, 13'h0000, 8'h00, 1'b1, 13'h1800);
    step(); step();
    check("rst_ready", 32'(cpu_ready), 32'd1);
    check("rst_gnt", 32'(ren_gnt), 32'd1);
    check("rst_rvalid", 32'(cpu_rvalid), 32'd0);
    check("rst_rdata", 32'(cpu_rdata), 32'hFF);
    check("rst_dropped", 32'(wr_dropped), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    load = 1'b0; rst = 1'b0;
    step();

    // Table: combinational routing, then registered read return
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].lcd, vecs[i].ph, vecs[i].rq, vecs[i].we, vecs[i].addr,
            vecs[i].wd, vecs[i].rr, vecs[i].raddr);
      #1;
      check($sformatf("v%0d_ready", i), 32'(cpu_ready), 32'(vecs[i].e_ready));
      check($sformatf("v%0d_gnt", i), 32'(ren_gnt), 32'(vecs[i].e_gnt));
      check($sformatf("v%0d_we", i), 32'(mem_we), 32'(vecs[i].e_we));
      check($sformatf("v%0d_maddr", i), 32'(mem_addr), 32'(vecs[i].e_maddr));
      step();
      cpu_req = 1'b0;
      check($sformatf("v%0d_rvalid", i), 32'(cpu_rvalid), 32'(vecs[i].e_rvalid));
      if (vecs[i].e_rvalid) check($sformatf("v%0d_rdata", i), 32'(cpu_rdata), 32'(vecs[i].e_rdata));
    end
    check("oam_write_landed", 32'(mem0[13'h0200]), 32'h66);

    // Renderer fetch during DRAW with a concurrent CPU read
    drive(1'b1, DR, 1'b1, 1'b0, 13'h0007, 8'h00, 1'b1, 13'h1800);
    #1;
    check("draw_gnt", 32'(ren_gnt), 32'd1);
    check("draw_mem_we", 32'(mem_we), 32'd0);
    step();
    cpu_req = 1'b0; ren_req = 1'b0;
    check("draw_ren_rdata", 32'(ren_rdata), 32'h42);
    check("draw_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
    check("draw_cpu_rdata", 32'(cpu_rdata), 32'hFF);
    step();

    // Posted write, stalled second write, drain, readback
    drive(1'b1, DR, 1'b1, 1'b1, 13'h0010, 8'hA5, 1'b1, 13'h1800);
    #1 check("post_accept", 32'(cpu_ready), 32'd1);
    step();
    cpu_addr = 13'h0011; cpu_wdata = 8'h3C;
    #1 check("post_stall0", 32'(cpu_ready), 32'd0);
    step();
    check("post_stall1", 32'(cpu_ready), 32'd0);
    check("post_not_landed", 32'(mem0[13'h0010]), 32'(pat(32'h10)));
    step();
    phase = HB;
    #1;
    check("full_hb_ready", 32'(cpu_ready), 32'd0);
    check("full_hb_we", 32'(mem_we), 32'd0);
    step();
    check("drain_we", 32'(mem_we), 32'd1);
    check("drain_addr", 32'(mem_addr), 32'h0010);
    check("drain_din", 32'(mem_din), 32'hA5);
    check("drain_ready", 32'(cpu_ready), 32'd0);
    check("drain_gnt", 32'(ren_gnt), 32'd0);
    step();
    check("second_ready", 32'(cpu_ready), 32'd1);
    check("second_we", 32'(mem_we), 32'd1);
    check("second_addr", 32'(mem_addr), 32'h0011);
    step();
    drive(1'b1, HB, 1'b1, 1'b0, 13'h0010, 8'h00, 1'b0, 13'h0000);
    step();
    cpu_req = 1'b0;
    check("readback_rvalid", 32'(cpu_rvalid), 32'd1);
    check("readback_rdata", 32'(cpu_rdata), 32'hA5);
    check("second_landed", 32'(mem0[13'h0011]), 32'h3C);
    check("post_never_drops", 32'(wr_dropped), 32'd0);

    // Dropping instance: 300 DRAW writes
    drive(1'b1, DR, 1'b0, 1'b0, 13'h0000, 8'h99, 1'b0, 13'h1800);
    d_cpu_req = 1'b1; d_cpu_we = 1'b1;
    for (int i = 0; i < 300; i++) begin
      cpu_addr = 13'(i % 16);
      #1;
      check("drop_ready", 32'(cpu_ready_d), 32'd1);
      check("drop_mem_we", 32'(mem_we_d), 32'd0);
      step();
      if (i == 0) check("drop_first", 32'(wr_dropped_d), 32'd1);
    end
    d_cpu_req = 1'b0;
    check("drop_saturated", 32'(wr_dropped_d), 32'd255);
    check("drop_vram_0", 32'(mem1[0]), 32'(pat(0)));
    check("drop_vram_15", 32'(mem1[15]), 32'(pat(15)));
    check("drop_rvalid", 32'(cpu_rvalid_d), 32'd0);
    check("drop_rdata", 32'(cpu_rdata_d), 32'hFF);
    check("drop_gnt", 32'(ren_gnt_d), 32'd0);
    check("drop_ren_rdata", 32'(ren_rdata_d), 32'h42);

    // CPU priority in HBLANK, then last-cycle read returns real data in DRAW
    drive(1'b1, HB, 1'b1, 1'b0, 13'h0020, 8'h00, 1'b1, 13'h1800);
    #1;
    check("prio_gnt", 32'(ren_gnt), 32'd0);
    check("prio_ready", 32'(cpu_ready), 32'd1);
    step();
    phase = DR; cpu_req = 1'b0;
    check("edge_rvalid", 32'(cpu_rvalid), 32'd1);
    check("edge_rdata", 32'(cpu_rdata), 32'hE3);
    step();

    // Reset while the buffer is full discards the pending write
    drive(1'b1, DR, 1'b1, 1'b1, 13'h0040, 8'h11, 1'b0, 13'h0000);
    step();
    cpu_req = 1'b0; cpu_we = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstfull_ready", 32'(cpu_ready), 32'd1);
    check("rstfull_rvalid", 32'(cpu_rvalid), 32'd0);
    phase = HB;
    for (int i = 0; i < 3; i++) begin
      #1 check("rstfull_no_we", 32'(mem_we), 32'd0);
      step();
    end
    check("rstfull_vram", 32'(mem0[13'h0040]), 32'(pat(32'h40)));

    // lcd_ena drop during DRAW drains, drain survives return to DRAW
    drive(1'b1, DR, 1'b1, 1'b1, 13'h0050, 8'h77, 1'b1, 13'h1800);
    step();
    cpu_req = 1'b0; lcd_ena = 1'b0;
    #1 check("lcdoff_ready", 32'(cpu_ready), 32'd0);
    step();
    lcd_ena = 1'b1;
    #1;
    check("lcdoff_drain_we", 32'(mem_we), 32'd1);
    check("lcdoff_drain_addr", 32'(mem_addr), 32'h0050);
    check("lcdoff_drain_din", 32'(mem_din), 32'h77);
    check("lcdoff_drain_gnt", 32'(ren_gnt), 32'd0);
    step();
    check("lcdoff_landed", 32'(mem0[13'h0050]), 32'h77);
    check("lcdoff_after_gnt", 32'(ren_gnt), 32'd1);
    check("lcdoff_after_ready", 32'(cpu_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
